mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester cacheline arbiter: the instruction and data caches share one physical-memory port.
// Ties alternate by last grant. The pmem request is held in registers until pmem_resp arrives.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction cache
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // Data cache
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // Physical memory
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  // Completed-transaction counters
  output logic [31:0]       i_grants,
  output logic [31:0]       d_grants
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2
  } state_e;

  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

  state_e state_q;
  logic   last_grant_q;
  logic   i_pend;
  logic   d_pend;
  logic   pick_i;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  // On a tie the requester that did not win last time gets the port.
  assign pick_i = i_pend & (~d_pend | (last_grant_q == GrantD));

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;
  assign i_resp  = (state_q == StServeI) & pmem_resp;
  assign d_resp  = (state_q == StServeD) & pmem_resp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_addr    <= '0;
      pmem_wdata   <= '0;
      i_grants     <= '0;
      d_grants     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_i) begin
            state_q      <= StServeI;
            last_grant_q <= GrantI;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_addr    <= i_addr;
            pmem_wdata   <= '0;
          end else if (d_pend) begin
            // A simultaneous read and write is treated as a writeback.
            state_q      <= StServeD;
            last_grant_q <= GrantD;
            pmem_read    <= ~d_write;
            pmem_write   <= d_write;
            pmem_addr    <= d_addr;
            pmem_wdata   <= d_wdata;
          end
        end
        StServeI: begin
          if (pmem_resp) begin
            state_q    <= StIdle;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
            i_grants   <= i_grants + 32'd1;
          end
        end
        StServeD: begin
          if (pmem_resp) begin
            state_q    <= StIdle;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
            d_grants   <= d_grants + 32'd1;
          end
        end
        default: begin
          state_q    <= StIdle;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          pmem_addr  <= '0;
          pmem_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs are sampled there
// or 1ns later for the combinational response path.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic [31:0]       i_grants;
  logic [31:0]       d_grants;

  int n_checks = 0;
  int n_fail   = 0;

  logic [LINE_W-1:0] line_aa;
  logic [LINE_W-1:0] line_55;
  logic [LINE_W-1:0] line_c3;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp),
    .i_grants   (i_grants),
    .d_grants   (d_grants)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    line_aa = {8{32'hAAAA_AAAA}};
    line_55 = {8{32'h5555_5555}};
    line_c3 = {8{32'hC3C3_C3C3}};

    // Reset state
    tick();
    check("rst_pmem_read", 256'(pmem_read), 256'd0);
    check("rst_pmem_write", 256'(pmem_write), 256'd0);
    check("rst_pmem_addr", 256'(pmem_addr), 256'd0);
    check("rst_pmem_wdata", pmem_wdata, 256'd0);
    check("rst_i_grants", 256'(i_grants), 256'd0);
    check("rst_d_grants", 256'(d_grants), 256'd0);
    reset = 1'b0;

    // Single instruction fill, response three cycles after the request
    tick();
    i_read = 1'b1;
    i_addr = 32'h0000_1000;
    tick();
    check("i1_pmem_read", 256'(pmem_read), 256'd1);
    check("i1_pmem_addr", 256'(pmem_addr), 256'h1000);
    i_read = 1'b0;
    i_addr = 32'h0000_9999;
    tick();
    check("i1_no_resp_yet", 256'(i_resp), 256'd0);
    check("i1_addr_held", 256'(pmem_addr), 256'h1000);
    tick();
    pmem_rdata = line_aa;
    pmem_resp  = 1'b1;
    #1;
    check("i1_i_resp", 256'(i_resp), 256'd1);
    check("i1_d_resp", 256'(d_resp), 256'd0);
    check("i1_i_rdata", i_rdata, line_aa);
    check("i1_d_rdata", d_rdata, line_aa);
    tick();
    pmem_resp = 1'b0;
    #1;
    check("i1_resp_pulse", 256'(i_resp), 256'd0);
    check("i1_idle_read", 256'(pmem_read), 256'd0);
    check("i1_i_grants", 256'(i_grants), 256'd1);

    // Simultaneous requests after reset: D first, one idle cycle, then I
    do_reset();
    i_read = 1'b1;
    i_addr = 32'h0000_1400;
    d_read = 1'b1;
    d_addr = 32'h0000_2400;
    tick();
    check("tie_first_d_addr", 256'(pmem_addr), 256'h2400);
    check("tie_first_read", 256'(pmem_read), 256'd1);
    pmem_resp = 1'b1;
    #1;
    check("tie_d_resp", 256'(d_resp), 256'd1);
    check("tie_no_i_resp", 256'(i_resp), 256'd0);
    tick();
    pmem_resp = 1'b0;
    check("tie_idle_gap", 256'(pmem_read), 256'd0);
    check("tie_d_grants", 256'(d_grants), 256'd1);
    tick();
    check("tie_second_i_addr", 256'(pmem_addr), 256'h1400);
    pmem_resp = 1'b1;
    #1;
    check("tie_i_resp", 256'(i_resp), 256'd1);
    check("tie_no_d_resp", 256'(d_resp), 256'd0);
    tick();
    pmem_resp = 1'b0;
    i_read = 1'b0;
    d_read = 1'b0;
    check("tie_i_grants", 256'(i_grants), 256'd1);

    // Both held for four transactions: D, I, D, I
    do_reset();
    i_read = 1'b1;
    i_addr = 32'h0000_1800;
    d_read = 1'b1;
    d_addr = 32'h0000_2800;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("alt_addr_%0d", k), 256'(pmem_addr),
            (k % 2 == 0) ? 256'h2800 : 256'h1800);
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      if (k == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
    end
    check("alt_i_grants", 256'(i_grants), 256'd2);
    check("alt_d_grants", 256'(d_grants), 256'd2);

    // Writeback with the address and data changing mid-transaction
    do_reset();
    d_write = 1'b1;
    d_addr  = 32'h0000_2000;
    d_wdata = line_55;
    tick();
    check("wr_pmem_write", 256'(pmem_write), 256'd1);
    check("wr_pmem_read", 256'(pmem_read), 256'd0);
    check("wr_addr", 256'(pmem_addr), 256'h2000);
    check("wr_wdata", pmem_wdata, line_55);
    d_addr  = 32'h0000_3000;
    d_wdata = line_c3;
    d_write = 1'b0;
    tick();
    check("wr_addr_held", 256'(pmem_addr), 256'h2000);
    check("wr_wdata_held", pmem_wdata, line_55);
    check("wr_write_held", 256'(pmem_write), 256'd1);
    pmem_resp = 1'b1;
    #1;
    check("wr_d_resp", 256'(d_resp), 256'd1);
    tick();
    pmem_resp = 1'b0;
    #1;
    check("wr_resp_once", 256'(d_resp), 256'd0);
    check("wr_done_write", 256'(pmem_write), 256'd0);
    check("wr_d_grants", 256'(d_grants), 256'd1);

    // Reset mid SERVE_I: outputs drop at once, late response ignored, counters cleared
    i_read = 1'b1;
    i_addr = 32'h0000_5000;
    tick();
    check("rmid_pmem_read", 256'(pmem_read), 256'd1);
    i_read = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rmid_read_drop", 256'(pmem_read), 256'd0);
    check("rmid_addr_drop", 256'(pmem_addr), 256'd0);
    check("rmid_d_grants", 256'(d_grants), 256'd0);
    tick();
    reset = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check("rmid_no_i_resp", 256'(i_resp), 256'd0);
    check("rmid_no_d_resp", 256'(d_resp), 256'd0);
    tick();
    pmem_resp = 1'b0;
    check("rmid_i_grants", 256'(i_grants), 256'd0);
    check("rmid_idle_read", 256'(pmem_read), 256'd0);

    // Read and write together behave as a write
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_4000;
    d_wdata = line_c3;
    tick();
    d_read  = 1'b0;
    d_write = 1'b0;
    check("rw_write", 256'(pmem_write), 256'd1);
    check("rw_read", 256'(pmem_read), 256'd0);
    tick();
    check("rw_write_hold", 256'(pmem_write), 256'd1);
    check("rw_read_hold", 256'(pmem_read), 256'd0);
    check("rw_wdata", pmem_wdata, line_c3);
    pmem_resp = 1'b1;
    #1;
    check("rw_d_resp", 256'(d_resp), 256'd1);
    tick();
    pmem_resp = 1'b0;
    check("rw_d_grants", 256'(d_grants), 256'd1);
    check("rw_i_grants", 256'(i_grants), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
